// File: rtl/mem_if_pkg.sv
// Shared types and constants for the button command mailbox (reader and writer sides).
package mem_if_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StCheck,
    StPresent,
    StClear
  } rd_state_t;

  localparam logic [31:0] CMD_NONE = 32'd0;
  localparam logic [31:0] CMD_BTN0 = 32'd1;
  localparam logic [31:0] CMD_BTN1 = 32'd2;

  localparam int unsigned MAILBOX_WORD_ADDR = 1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Saturating up/down counter with synchronous clear/load and a terminal-count flag.
module poll_timer #(
  parameter int unsigned    Width     = 4,
  parameter bit             CountDown = 1'b0,
  parameter logic [Width-1:0] Terminal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == Terminal);

  // Counting stops at the terminal value; the owner clears or reloads it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !tc_o) begin
      cnt_d = CountDown ? (cnt_q - Width'(1)) : (cnt_q + Width'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/read_mem.sv
// Mailbox reader: polls a memory word, presents non-zero words as commands, then clears it.
module read_mem
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAILBOX_ADDR  = MAILBOX_WORD_ADDR,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned POLL_INTERVAL = 1000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cmd_valid,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_ready,
  output logic              busy
);

  localparam int unsigned PollW = cnt_width(POLL_INTERVAL);
  localparam int unsigned LatW  = cnt_width(READ_LATENCY);
  localparam logic [PollW-1:0]  PollLast = PollW'(POLL_INTERVAL - 1);
  localparam logic [LatW-1:0]   LatLoad  = LatW'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] MbAddr   = ADDR_W'(MAILBOX_ADDR);

  rd_state_t         state_q, state_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              rd_en_q, rd_en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              poll_tc, lat_tc;

  poll_timer #(
    .Width     (PollW),
    .CountDown (1'b0),
    .Terminal  (PollLast)
  ) u_poll_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    ((state_q != StIdle) || poll_tc),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == StIdle),
    .tc_o       (poll_tc)
  );

  poll_timer #(
    .Width     (LatW),
    .CountDown (1'b1),
    .Terminal  ('0)
  ) u_lat_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (1'b0),
    .load_i     (state_q == StRead),
    .load_val_i (LatLoad),
    .en_i       (state_q == StWait),
    .tc_o       (lat_tc)
  );

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    state_d    = state_q;
    cmd_data_d = cmd_data_q;
    unique case (state_q)
      StIdle:    if (poll_tc) state_d = StRead;
      StRead:    state_d = StWait;
      StWait: begin
        if (lat_tc) begin
          cmd_data_d = mem_rdata;
          state_d    = StCheck;
        end
      end
      StCheck:   state_d = (cmd_data_q == DATA_W'(CMD_NONE)) ? StIdle : StPresent;
      StPresent: if (cmd_valid_q && cmd_ready) state_d = StClear;
      StClear:   state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    rd_en_d     = (state_d == StRead);
    we_d        = (state_d == StClear);
    addr_d      = (rd_en_d || we_d) ? MbAddr : '0;
    cmd_valid_d = (state_d == StPresent);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      rd_en_q     <= rd_en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_we    = we_q;
  assign mem_wdata = '0;
  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_read_mem.sv
// Directed bench for read_mem: main instance (latency 2) plus latency-1 and latency-3 builds.
`timescale 1ns/1ps
module tb_read_mem;
  import mem_if_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned P  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_we, cmd_valid, cmd_ready, busy;
  logic [DW-1:0] mem_rdata, mem_wdata, cmd_data;

  // Mailbox memory model for the main instance; read data follows the stored word.
  logic [DW-1:0] mbox = '0;
  logic [DW-1:0] tb_wdata = '0;
  logic          tb_wr = 1'b0;
  assign mem_rdata = mbox;
  always @(posedge clk) begin
    if (mem_we && mem_addr == AW'(1)) mbox <= mem_wdata;
    else if (tb_wr) mbox <= tb_wdata;
  end

  read_mem #(
    .ADDR_W(AW), .DATA_W(DW), .MAILBOX_ADDR(1), .READ_LATENCY(2), .POLL_INTERVAL(P)
  ) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .busy(busy)
  );

  logic          l_rd_en[2], l_we[2], l_valid[2], l_busy[2];
  logic [AW-1:0] l_addr[2];
  logic [DW-1:0] l_rdata[2], l_wdata[2], l_data[2];

  read_mem #(
    .ADDR_W(AW), .DATA_W(DW), .MAILBOX_ADDR(1), .READ_LATENCY(1), .POLL_INTERVAL(P)
  ) u_lat1 (
    .clk(clk), .rst(rst), .mem_addr(l_addr[0]), .mem_rd_en(l_rd_en[0]),
    .mem_rdata(l_rdata[0]), .mem_we(l_we[0]), .mem_wdata(l_wdata[0]),
    .cmd_valid(l_valid[0]), .cmd_data(l_data[0]), .cmd_ready(1'b1), .busy(l_busy[0])
  );

  read_mem #(
    .ADDR_W(AW), .DATA_W(DW), .MAILBOX_ADDR(1), .READ_LATENCY(3), .POLL_INTERVAL(P)
  ) u_lat3 (
    .clk(clk), .rst(rst), .mem_addr(l_addr[1]), .mem_rd_en(l_rd_en[1]),
    .mem_rdata(l_rdata[1]), .mem_we(l_we[1]), .mem_wdata(l_wdata[1]),
    .cmd_valid(l_valid[1]), .cmd_data(l_data[1]), .cmd_ready(1'b1), .busy(l_busy[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mbox(input logic [DW-1:0] v);
    tb_wdata = v;
    tb_wr    = 1'b1;
    step();
    tb_wr    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({mem_rd_en, mem_we, cmd_valid, busy} !== 4'b0000 || mem_addr !== '0 ||
        cmd_data !== '0 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd_en=%b we=%b valid=%b busy=%b addr=%0h data=%0h, want all 0",
               mem_rd_en, mem_we, cmd_valid, busy, mem_addr, cmd_data);
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (mem_rd_en !== (i == 4) || busy !== (i == 4)) begin
        failures++;
        $display("FAIL first_poll cycle %0d: rd_en=%b busy=%b, want %b", i, mem_rd_en, busy,
                 i == 4);
      end
    end
    checks++;
    if (mem_addr !== AW'(1) || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL read_strobe: addr=%0h we=%b, want addr=1 we=0", mem_addr, mem_we);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({mem_rd_en, mem_we, cmd_valid, busy} !== 4'b0001 || mem_addr !== '0) begin
        failures++;
        $display("FAIL empty_poll cycle %0d: rd_en=%b we=%b valid=%b busy=%b addr=%0h", i,
                 mem_rd_en, mem_we, cmd_valid, busy, mem_addr);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_poll_idle: busy=%b valid=%b, want 0 0", busy, cmd_valid);
    end
  endtask

  task automatic wait_rd(input string name);
    int n = 0;
    while (!mem_rd_en && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (mem_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL %s: rd_en=%b after %0d cycles, want 1", name, mem_rd_en, n);
    end
  endtask

  task automatic test_ready_high();
    cmd_ready = 1'b1;
    set_mbox(CMD_BTN0);
    wait_rd("ready_high_poll");
    for (int i = 1; i <= 3; i++) step();
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL ready_high_early_valid: valid=%b, want 0", cmd_valid);
    end
    step();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== DW'(1)) begin
      failures++;
      $display("FAIL ready_high_present: valid=%b data=%0h, want 1 1", cmd_valid, cmd_data);
    end
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(1) || mem_wdata !== '0 || mem_rd_en !== 1'b0 ||
        cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL ready_high_clear: we=%b addr=%0h wdata=%0h rd_en=%b valid=%b", mem_we,
               mem_addr, mem_wdata, mem_rd_en, cmd_valid);
    end
    step();
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mbox !== '0) begin
      failures++;
      $display("FAIL ready_high_after: we=%b busy=%b mbox=%0h, want 0 0 0", mem_we, busy, mbox);
    end
    wait_rd("ready_high_repoll");
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_high_repoll_empty: valid=%b busy=%b, want 0 0", cmd_valid, busy);
    end
  endtask

  task automatic test_ready_low();
    cmd_ready = 1'b0;
    set_mbox(CMD_BTN1);
    wait_rd("ready_low_poll");
    for (int i = 1; i <= 4; i++) step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_data !== DW'(2) || mem_we !== 1'b0) begin
        failures++;
        $display("FAIL ready_low_hold cycle %0d: valid=%b data=%0h we=%b, want 1 2 0", i,
                 cmd_valid, cmd_data, mem_we);
      end
      if (i < 9) step();
    end
    cmd_ready = 1'b1;
    step();
    checks++;
    if (mem_we !== 1'b1 || cmd_valid !== 1'b0 || mem_addr !== AW'(1)) begin
      failures++;
      $display("FAIL ready_low_clear: we=%b valid=%b addr=%0h, want 1 0 1", mem_we, cmd_valid,
               mem_addr);
    end
    step();
    checks++;
    if (mem_we !== 1'b0 || mbox !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ready_low_after: we=%b mbox=%0h busy=%b, want 0 0 0", mem_we, mbox, busy);
    end
  endtask

  task automatic test_rst_present();
    int n = 0;
    cmd_ready = 1'b0;
    set_mbox(CMD_BTN0);
    wait_rd("rst_present_poll");
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_present_valid: valid=%b, want 1", cmd_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({mem_rd_en, mem_we, cmd_valid, busy} !== 4'b0000 || mem_addr !== '0 ||
        cmd_data !== '0 || mbox !== DW'(1)) begin
      failures++;
      $display("FAIL rst_present_drop: rd_en=%b we=%b valid=%b busy=%b addr=%0h data=%0h mbox=%0h",
               mem_rd_en, mem_we, cmd_valid, busy, mem_addr, cmd_data, mbox);
    end
    while (!mem_rd_en && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n != P || mem_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL rst_repoll_delay: rd_en after %0d cycles, want %0d", n, P);
    end
    for (int i = 1; i <= 4; i++) step();
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== DW'(1)) begin
      failures++;
      $display("FAIL rst_represent: valid=%b data=%0h, want 1 1", cmd_valid, cmd_data);
    end
    cmd_ready = 1'b1;
    step();
    step();
    checks++;
    if (mbox !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_final_clear: mbox=%0h busy=%b, want 0 0", mbox, busy);
    end
  endtask

  task automatic test_overwrite();
    cmd_ready = 1'b0;
    set_mbox(CMD_BTN0);
    wait_rd("overwrite_poll");
    for (int i = 1; i <= 3; i++) step();
    set_mbox(CMD_BTN1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== DW'(1) || mbox !== DW'(2)) begin
      failures++;
      $display("FAIL overwrite_present: valid=%b data=%0h mbox=%0h, want 1 1 2", cmd_valid,
               cmd_data, mbox);
    end
    cmd_ready = 1'b1;
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== '0) begin
      failures++;
      $display("FAIL overwrite_clear: we=%b wdata=%0h, want 1 0", mem_we, mem_wdata);
    end
    step();
    checks++;
    if (mbox !== '0 || cmd_data !== DW'(1)) begin
      failures++;
      $display("FAIL overwrite_lost: mbox=%0h data=%0h, want 0 1", mbox, cmd_data);
    end
  endtask

  // a on the cycles just before/after the sample cycle, b exactly on it.
  task automatic lat_poll(input int k, input int lat, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
    int n = 0;
    while (!l_rd_en[k] && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (l_rd_en[k] !== 1'b1) begin
      failures++;
      $display("FAIL lat%0d_poll_timeout: rd_en=%b", lat, l_rd_en[k]);
    end
    for (int c = 0; c <= lat + 1; c++) begin
      l_rdata[k] = (c == lat) ? b : ((c == lat - 1 || c == lat + 1) ? a : '0);
      step();
    end
    l_rdata[k] = '0;
  endtask

  task automatic test_latency(input int k);
    int lat = (k == 0) ? 1 : 3;
    lat_poll(k, lat, DW'(9), DW'(0));
    checks++;
    if (l_valid[k] !== 1'b0 || l_busy[k] !== 1'b0) begin
      failures++;
      $display("FAIL lat%0d_off_cycle: valid=%b busy=%b, want 0 0", lat, l_valid[k], l_busy[k]);
    end
    lat_poll(k, lat, DW'(9), DW'(7));
    checks++;
    if (l_valid[k] !== 1'b1 || l_data[k] !== DW'(7)) begin
      failures++;
      $display("FAIL lat%0d_capture: valid=%b data=%0h, want 1 7", lat, l_valid[k], l_data[k]);
    end
    step();
    checks++;
    if (l_we[k] !== 1'b1 || l_addr[k] !== AW'(1) || l_wdata[k] !== '0) begin
      failures++;
      $display("FAIL lat%0d_clear: we=%b addr=%0h wdata=%0h, want 1 1 0", lat, l_we[k],
               l_addr[k], l_wdata[k]);
    end
    step();
    checks++;
    if (l_busy[k] !== 1'b0 || l_we[k] !== 1'b0) begin
      failures++;
      $display("FAIL lat%0d_idle: busy=%b we=%b, want 0 0", lat, l_busy[k], l_we[k]);
    end
  endtask

  initial begin
    cmd_ready  = 1'b0;
    l_rdata[0] = '0;
    l_rdata[1] = '0;
    test_reset();
    test_ready_high();
    test_ready_low();
    test_rst_present();
    test_overwrite();
    test_latency(0);
    test_latency(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/read_mem.md
# read_mem

Memory-side reader for the button command mailbox. Polls a fixed mailbox word in data memory on a programmable interval and waits out the synchronous RAM read latency. Presents any non-zero word as a command to downstream game/display logic over a valid/ready handshake, then clears the mailbox by writing zero so each button press is consumed exactly once. Sits between the shared data memory port and the command consumer, opposite the button-driven writer.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- MAILBOX_ADDR, 1, word address polled and cleared
- READ_LATENCY, 2, cycles from mem_rd_en high to mem_rdata valid (≥1)
- POLL_INTERVAL, 1000, cycles spent in IDLE between polls (≥1)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_addr  out  ADDR_W  memory address
- mem_rd_en  out  1  one-cycle read strobe
- mem_rdata  in  DATA_W  read data, valid READ_LATENCY cycles after strobe
- mem_we  out  1  one-cycle write strobe
- mem_wdata  out  DATA_W  write data (always 0)
- cmd_valid  out  1  command available
- cmd_data  out  DATA_W  captured mailbox word
- cmd_ready  in  1  consumer accepts command
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, READ, WAIT, CHECK, PRESENT, CLEAR.
- IDLE: poll counter increments each cycle; at POLL_INTERVAL-1, counter resets to 0, go READ.
- READ: mem_rd_en=1, mem_addr=MAILBOX_ADDR for exactly one cycle; latency counter loaded to READ_LATENCY-1; go WAIT.
- WAIT: decrement latency counter; at 0, capture mem_rdata into cmd_data register; go CHECK.
- CHECK: captured word 0 → IDLE (no command); non-zero → PRESENT.
- PRESENT: cmd_valid=1, cmd_data stable; on cmd_valid&&cmd_ready → CLEAR. No timeout; holds indefinitely.
- CLEAR: mem_we=1, mem_addr=MAILBOX_ADDR, mem_wdata=0 for one cycle; → IDLE.
- mem_rd_en and mem_we never high in the same cycle; mem_addr = MAILBOX_ADDR whenever either strobe is high, 0 otherwise.
- cmd_data changes only in WAIT's capture cycle; all other states hold it.
- Writer overwriting the mailbox between capture and CLEAR: overwritten command is lost by design. Consumers accept this single-slot semantics.

## Timing
- Reset: state=IDLE, poll counter=0, latency counter=0, cmd_data=0, cmd_valid=0, mem_rd_en=0, mem_we=0, mem_wdata=0, mem_addr=0, busy=0.
- rst takes priority in any state; asserted mid-PRESENT, cmd_valid drops the next cycle and no CLEAR write is issued.
- First READ strobe occurs POLL_INTERVAL cycles after rst deasserts.
- Mailbox=0 poll: READ(1) + WAIT(READ_LATENCY) + CHECK(1), then IDLE.
- Non-zero poll: cmd_valid rises READ_LATENCY+2 cycles after the READ strobe; CLEAR strobe is the cycle after the handshake; IDLE follows.
- cmd_ready high before cmd_valid has no effect; handshake is the cycle both are high.
- Counters sized $clog2 of their parameter (min 1 bit); no wrap beyond the terminal value.

## Structure
- Package `mem_if_pkg`: state enum `rd_state_t`; command constants CMD_NONE=0, CMD_BTN0=1, CMD_BTN1=2 (shared with the writer); mailbox address constant.
- Sub-module `poll_timer`: parameterised down/up counter with clear and terminal-count pulse, reused for the poll interval and the latency wait.
- Single always_ff for state/registers, always_comb for strobes and next state.

## Test plan
- Reset, mailbox holds 0, POLL_INTERVAL=4, READ_LATENCY=2 → rd_en pulse at cycle 4 after reset release, no cmd_valid, no mem_we, back in IDLE.
- Mailbox=1, cmd_ready tied high → cmd_valid with cmd_data=1 four cycles after rd_en, one-cycle mem_we with addr=1, wdata=0; next poll reads 0.
- Mailbox=2, cmd_ready low for 10 cycles → cmd_valid and cmd_data=2 stable for all 10 cycles, no write until ready rises, CLEAR the following cycle.
- READ_LATENCY=1 and =3 builds → capture from mem_rdata exactly at the configured cycle; mem_rdata changed one cycle early/late is not captured.
- rst asserted during PRESENT → cmd_valid=0 next cycle, no mem_we, outputs at reset values; mailbox still 1 and re-presented on the next poll.
- Mailbox changes 1→2 during WAIT after capture → cmd_data=1 presented; CLEAR zeros the mailbox (2 lost) as specified.
